// File: rtl/slave_response_tracker.sv
// Per-slave-port ID tracker: gates address issue, routes responses by ID.
// Optional CAXI4_RESP_ERR_CHECK_EN flags last beats for untracked IDs.
module slave_response_tracker #(
  parameter int MASTERID_WIDTH   = 4,
  parameter int NUM_MASTERS_WIDTH = 2,
  parameter int TRACK_DEPTH      = 4,
  parameter int OPEN_TRANS_MAX   = 3,
  parameter int OPEN_TRANS_WIDTH = 2,
  parameter int TOTAL_CNT_WIDTH  = 4
) (
  input  logic                         sysClk,
  input  logic                         sysReset,
  input  logic                         addrValid,
  input  logic [MASTERID_WIDTH-1:0]    addrID,
  output logic                         addrReady,
  output logic                         slaveAddrValid,
  input  logic                         slaveAddrReady,
  input  logic                         slaveRespValid,
  input  logic [MASTERID_WIDTH-1:0]    slaveRespID,
  input  logic                         slaveRespLast,
  output logic                         slaveRespReady,
  output logic                         masterRespValid,
  input  logic                         masterRespReady,
  output logic [NUM_MASTERS_WIDTH-1:0] respMasterPort,
  output logic [TOTAL_CNT_WIDTH-1:0]   openCount,
  output logic                         idle,
  output logic                         respUnexpected
);

  localparam int IdxW = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
  localparam logic [OPEN_TRANS_WIDTH-1:0] MaxCnt =
    OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);
  localparam logic [OPEN_TRANS_WIDTH-1:0] OneCnt =
    OPEN_TRANS_WIDTH'(1);

  logic [TRACK_DEPTH-1:0]      entValid;
  logic [MASTERID_WIDTH-1:0]   entId  [TRACK_DEPTH];
  logic [OPEN_TRANS_WIDTH-1:0] entCnt [TRACK_DEPTH];

  logic            addrHit, respHit, freeAny;
  logic [IdxW-1:0] addrIdx, respIdx, freeIdx;
  logic            trackOK, accept, respDone, respDoneHit;
  logic [TRACK_DEPTH-1:0] incVec, decVec;

  // Descending scan so the lowest-index free entry wins
  always_comb begin
    addrHit = 1'b0;
    respHit = 1'b0;
    freeAny = 1'b0;
    addrIdx = '0;
    respIdx = '0;
    freeIdx = '0;
    for (int i = TRACK_DEPTH - 1; i >= 0; i--) begin
      if (entValid[i] && entId[i] == addrID) begin
        addrHit = 1'b1;
        addrIdx = IdxW'(i);
      end
      if (entValid[i] && entId[i] == slaveRespID) begin
        respHit = 1'b1;
        respIdx = IdxW'(i);
      end
      if (!entValid[i]) begin
        freeAny = 1'b1;
        freeIdx = IdxW'(i);
      end
    end
  end

  assign trackOK = addrHit ? (entCnt[addrIdx] < MaxCnt) : freeAny;
  assign slaveAddrValid = addrValid & trackOK;
  assign addrReady      = slaveAddrReady & trackOK;
  assign accept = addrValid & slaveAddrReady & trackOK;

  assign respDone    = slaveRespValid & masterRespReady & slaveRespLast;
  assign respDoneHit = respDone & respHit;

  assign masterRespValid = slaveRespValid;
  assign slaveRespReady  = masterRespReady;
  assign respMasterPort  =
    slaveRespID[MASTERID_WIDTH-1 -: NUM_MASTERS_WIDTH];

  always_comb begin
    incVec = '0;
    decVec = '0;
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      incVec[i] = accept &&
        (addrHit ? addrIdx == IdxW'(i) : freeIdx == IdxW'(i));
      decVec[i] = respDoneHit && respIdx == IdxW'(i);
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      entValid  <= '0;
      openCount <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        entId[i]  <= '0;
        entCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        if (incVec[i] && !decVec[i]) begin
          if (!entValid[i]) begin
            entValid[i] <= 1'b1;
            entId[i]    <= addrID;
            entCnt[i]   <= OneCnt;
          end else begin
            entCnt[i] <= entCnt[i] + OneCnt;
          end
        end else if (decVec[i] && !incVec[i]) begin
          entCnt[i] <= entCnt[i] - OneCnt;
          if (entCnt[i] == OneCnt)
            entValid[i] <= 1'b0;
        end
      end
      unique case ({accept, respDoneHit})
        2'b10:   openCount <= openCount + TOTAL_CNT_WIDTH'(1);
        2'b01:   openCount <= openCount - TOTAL_CNT_WIDTH'(1);
        default: openCount <= openCount;
      endcase
    end
  end

  assign idle = (openCount == '0);

`ifdef CAXI4_RESP_ERR_CHECK_EN
  assign respUnexpected = respDone & ~respHit;
`else
  assign respUnexpected = 1'b0;
`endif

endmodule

// File: doc/slave_response_tracker.md
# slave_response_tracker

Slave-side counterpart to the crossbar's per-master transaction control: one instance sits on each slave port and tracks transactions forwarded to that slave by ID. It gates address issue when tracking capacity is exhausted. It routes each returning response back to the originating master port, decoded from the infrastructure bits of the ID. It decrements per-ID open counts on the last beat and reports the port's total outstanding count and idle state to the arbitration logic.

## Interface
- MASTERID_WIDTH, 4, full transaction ID width: infrastructure master bits in the MSBs, requestor ID below.
- NUM_MASTERS_WIDTH, 2, infrastructure master bits at the top of the ID.
- TRACK_DEPTH, 4, number of distinct IDs trackable at once.
- OPEN_TRANS_MAX, 3, maximum outstanding transactions per tracked ID.
- OPEN_TRANS_WIDTH, 2, width of the per-entry count; must hold OPEN_TRANS_MAX.
- TOTAL_CNT_WIDTH, 4, width of openCount; must hold TRACK_DEPTH*OPEN_TRANS_MAX.

- sysClk  in  1  clock.
- sysReset  in  1  reset; synchronous, active-high.
- addrValid  in  1  address request from crossbar to this slave.
- addrID  in  MASTERID_WIDTH  ID of the request.
- addrReady  out  1  request accepted toward crossbar.
- slaveAddrValid  out  1  address valid to slave.
- slaveAddrReady  in  1  slave address ready.
- slaveRespValid  in  1  response beat from slave.
- slaveRespID  in  MASTERID_WIDTH  response ID.
- slaveRespLast  in  1  last beat of the response.
- slaveRespReady  out  1  ready to slave.
- masterRespValid  out  1  routed response valid.
- masterRespReady  in  1  ready from the selected master path.
- respMasterPort  out  NUM_MASTERS_WIDTH  destination master, equal to slaveRespID[MSBs].
- openCount  out  TOTAL_CNT_WIDTH  total outstanding transactions.
- idle  out  1  high when openCount == 0.
- respUnexpected  out  1  one-cycle pulse on an untracked response; present only with the macro, otherwise tied 0.

## Operation
- Table of TRACK_DEPTH entries. Each entry holds {valid, id, count}.
- trackOK is high when either condition holds:
  - a valid entry matches addrID with count < OPEN_TRANS_MAX;
  - no entry matches and a free entry exists.
- slaveAddrValid = addrValid & trackOK. addrReady = slaveAddrReady & trackOK.
- accept = addrValid & slaveAddrReady & trackOK.
- On accept:
  - matching entry: count increments;
  - otherwise: the lowest-index free entry is written with valid=1, id=addrID, count=1.
- respDone = slaveRespValid & masterRespReady & slaveRespLast, applied to the entry matching slaveRespID.
  - That entry's count decrements.
  - When the count reaches 0 and there is no simultaneous accept for the same ID, valid clears.
- Same ID, accept and respDone in the same cycle: count unchanged and the entry stays valid.
- Different IDs in the same cycle: both updates apply independently. A freed entry becomes allocatable from the next cycle only.
- openCount changes by +1 on accept and -1 on respDone, net 0 when both occur. It never wraps, by construction of the tracking limits.
- Response path is combinational pass-through:
  - masterRespValid = slaveRespValid;
  - slaveRespReady = masterRespReady;
  - respMasterPort = slaveRespID[MASTERID_WIDTH-1 -: NUM_MASTERS_WIDTH].
- Non-last beats have no effect on the table.

## Timing
- Reset values: all entries invalid, count 0; openCount 0; idle 1; respUnexpected 0.
- Combinational outputs (addrReady, slaveAddrValid, masterRespValid, slaveRespReady, respMasterPort) follow their inputs and table state; they do not depend on reset directly.
- trackOK depends on registered table state only. Zero-cycle latency from addrValid to slaveAddrValid.
- Table, openCount and idle update on the sysClk edge following accept or respDone.
- Assertion of sysReset mid-operation discards all tracking on the next edge; in-flight responses are then treated as untracked.
- Table full with no match, or matching entry at OPEN_TRANS_MAX: addrReady=0 and slaveAddrValid=0 until a respDone frees capacity. Capacity is visible one cycle after that respDone.

## Configuration
- Macro: CAXI4_RESP_ERR_CHECK_EN.
- Defined, a last beat whose ID matches no valid entry:
  - is still forwarded;
  - pulses respUnexpected for that handshake cycle;
  - leaves the table and openCount unchanged.
- Undefined: no ID check is performed and respUnexpected is constant 0. An unmatched respDone still leaves state unchanged.

## Test plan
- Reset -> idle=1, openCount=0, respUnexpected=0. First addrValid with ID 0x5 and slaveAddrReady=1 -> addrReady=1; next cycle openCount=1, idle=0.
- Three accepts of ID 0x5 -> the fourth has slaveAddrValid=0 and addrReady=0. One respDone for ID 0x5 -> the following cycle addrReady=1.
- Accept IDs 0x1, 0x4, 0x9, 0xC once each -> ID 0x2 is blocked. ID 0x1 respDone frees its entry -> ID 0x2 is accepted the next cycle.
- Same-cycle accept and respDone on ID 0x9 at count 1 -> count stays 1, entry stays valid, openCount unchanged.
- Response beats ID 0xB with last=0, then last=1 -> respMasterPort=2'b10 on both beats; only the last beat decrements; masterRespReady=0 stalls slaveRespReady=0.
- With CAXI4_RESP_ERR_CHECK_EN defined: last beat for untracked ID 0x7 -> respUnexpected=1 for one cycle, openCount unchanged. Without the macro the same stimulus leaves respUnexpected at 0.
